// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
//   Owns the fetch PC and selects the next fetch address each cycle from
//   sequential PC+4, the branch predictor target, or a corrected target coming
//   back from ID-stage branch resolution. On a mispredict it redirects fetch,
//   pulses Flush, and inserts one bubble. It also returns training updates to
//   the predictor and keeps saturating branch / mispredict counters.
//
// Ports
//   CLK, RESET                    clock, asynchronous active-low reset
//   STALL                         IF stage cannot take a new PC this cycle
//   Pred_Valid/Taken/Target       predictor output for the current Fetch_PC
//   Resolve_*                     ID-stage resolution of a branch or jump
//   Fetch_PC, Fetch_Valid         address to fetch and real-fetch qualifier
//   Flush                         kill IF instructions younger than delay slot
//   Update_Valid/PC/Taken/Target  predictor training strobe and payload
//   Branch_Count, Mispredict_Count saturating event counters
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             Pred_Valid,
  input  logic             Pred_Taken,
  input  logic [31:0]      Pred_Target,
  input  logic             Resolve_Valid,
  input  logic             Resolve_Taken,
  input  logic [31:0]      Resolve_Target,
  input  logic [31:0]      Resolve_PC_Plus4,
  input  logic             Resolve_PredTaken,
  input  logic [31:0]      Resolve_PredTarget,
  output logic [31:0]      Fetch_PC,
  output logic             Fetch_Valid,
  output logic             Flush,
  output logic             Update_Valid,
  output logic [31:0]      Update_PC,
  output logic             Update_Taken,
  output logic [31:0]      Update_Target,
  output logic [CNT_W-1:0] Branch_Count,
  output logic [CNT_W-1:0] Mispredict_Count
);

  typedef enum logic [1:0] {BOOT, RUN, RECOVER} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] corrected_pc;
  logic        flush_nxt;
  logic        mp;
  logic        active;

  // Fetch addresses are word aligned; any loaded target drops its low bits.
  function automatic logic [31:0] align_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Resolution is ignored entirely while booting.
  assign active = (state != BOOT);

  // Wrong direction, or right "taken" direction but wrong target.
  assign mp = Resolve_Valid &
              ((Resolve_Taken != Resolve_PredTaken) |
               (Resolve_Taken & Resolve_PredTaken &
                (Resolve_Target != Resolve_PredTarget)));

  // Not-taken resumes after the delay slot, which is always kept.
  assign corrected_pc = align_addr(Resolve_Taken ? Resolve_Target
                                                 : Resolve_PC_Plus4 + 32'd4);

  assign Fetch_Valid = (state == RUN);

  always_comb begin
    state_nxt = state;
    pc_nxt    = Fetch_PC;
    flush_nxt = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      default: begin
        if (mp) begin
          // A redirect overrides STALL and restarts RECOVER if already there.
          pc_nxt    = corrected_pc;
          flush_nxt = 1'b1;
          state_nxt = RECOVER;
        end else if (!STALL) begin
          if (state == RECOVER) begin
            state_nxt = RUN;
          end else if (Pred_Valid && Pred_Taken) begin
            pc_nxt = align_addr(Pred_Target);
          end else begin
            pc_nxt = Fetch_PC + 32'd4;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state            <= BOOT;
      Fetch_PC         <= RESET_VECTOR;
      Flush            <= 1'b0;
      Update_Valid     <= 1'b0;
      Update_PC        <= '0;
      Update_Taken     <= 1'b0;
      Update_Target    <= '0;
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else begin
      state        <= state_nxt;
      Fetch_PC     <= pc_nxt;
      Flush        <= flush_nxt;
      Update_Valid <= Resolve_Valid & active;
      if (Resolve_Valid && active) begin
        Update_PC     <= Resolve_PC_Plus4 - 32'd4;
        Update_Taken  <= Resolve_Taken;
        Update_Target <= Resolve_Target;
        Branch_Count  <= sat_inc(Branch_Count);
        if (mp) begin
          Mispredict_Count <= sat_inc(Mispredict_Count);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam int          CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          STALL;
  logic          Pred_Valid, Pred_Taken;
  logic [31:0]   Pred_Target;
  logic          Resolve_Valid, Resolve_Taken, Resolve_PredTaken;
  logic [31:0]   Resolve_Target, Resolve_PC_Plus4, Resolve_PredTarget;
  logic [31:0]   Fetch_PC;
  logic          Fetch_Valid, Flush, Update_Valid, Update_Taken;
  logic [31:0]   Update_PC, Update_Target;
  logic [CW-1:0] Branch_Count, Mispredict_Count;

  fetch_redirect_ctrl #(.RESET_VECTOR(RV), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .Pred_Valid(Pred_Valid), .Pred_Taken(Pred_Taken), .Pred_Target(Pred_Target),
    .Resolve_Valid(Resolve_Valid), .Resolve_Taken(Resolve_Taken),
    .Resolve_Target(Resolve_Target), .Resolve_PC_Plus4(Resolve_PC_Plus4),
    .Resolve_PredTaken(Resolve_PredTaken), .Resolve_PredTarget(Resolve_PredTarget),
    .Fetch_PC(Fetch_PC), .Fetch_Valid(Fetch_Valid), .Flush(Flush),
    .Update_Valid(Update_Valid), .Update_PC(Update_PC), .Update_Taken(Update_Taken),
    .Update_Target(Update_Target), .Branch_Count(Branch_Count),
    .Mispredict_Count(Mispredict_Count)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: booting flag, bubble flag, current PC, and the last
  // values expected on the registered outputs.
  bit          m_boot, m_bubble, m_flush, m_uv, m_ut;
  logic [31:0] m_pc, m_upc, m_utgt;
  int          m_bc, m_mc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},    Fetch_PC, m_pc);
    check_eq({tag, ".valid"}, 32'(Fetch_Valid), 32'(!m_boot && !m_bubble));
    check_eq({tag, ".flush"}, 32'(Flush), 32'(m_flush));
    check_eq({tag, ".uv"},    32'(Update_Valid), 32'(m_uv));
    check_eq({tag, ".upc"},   Update_PC, m_upc);
    check_eq({tag, ".ut"},    32'(Update_Taken), 32'(m_ut));
    check_eq({tag, ".utgt"},  Update_Target, m_utgt);
    check_eq({tag, ".bc"},    32'(Branch_Count), 32'(m_bc));
    check_eq({tag, ".mc"},    32'(Mispredict_Count), 32'(m_mc));
  endtask

  task automatic model_reset();
    m_boot = 1; m_bubble = 0; m_flush = 0; m_uv = 0; m_ut = 0;
    m_pc = RV; m_upc = 0; m_utgt = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic clear_inputs();
    STALL = 0; Pred_Valid = 0; Pred_Taken = 0; Pred_Target = 0;
    Resolve_Valid = 0; Resolve_Taken = 0; Resolve_Target = 0;
    Resolve_PC_Plus4 = 0; Resolve_PredTaken = 0; Resolve_PredTarget = 0;
  endtask

  // Advance the model by one edge using the current inputs, then check.
  task automatic step(input string tag);
    bit mp;
    mp = Resolve_Valid && ((Resolve_Taken != Resolve_PredTaken) ||
         (Resolve_Taken && Resolve_PredTaken && Resolve_Target != Resolve_PredTarget));
    if (m_boot) begin
      m_boot = 0; m_flush = 0; m_uv = 0;
    end else begin
      m_uv = Resolve_Valid;
      if (Resolve_Valid) begin
        m_upc  = Resolve_PC_Plus4 - 32'd4;
        m_ut   = Resolve_Taken;
        m_utgt = Resolve_Target;
        if (m_bc < CMAX) m_bc++;
        if (mp && m_mc < CMAX) m_mc++;
      end
      if (mp) begin
        m_pc = (Resolve_Taken ? Resolve_Target : Resolve_PC_Plus4 + 32'd4) & 32'hFFFFFFFC;
        m_flush = 1; m_bubble = 1;
      end else begin
        m_flush = 0;
        if (!STALL) begin
          if (m_bubble) m_bubble = 0;
          else if (Pred_Valid && Pred_Taken) m_pc = Pred_Target & 32'hFFFFFFFC;
          else m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic set_resolve(input bit pt, input bit t, input logic [31:0] tgt,
                             input logic [31:0] ptgt, input logic [31:0] pc4);
    Resolve_Valid = 1; Resolve_PredTaken = pt; Resolve_Taken = t;
    Resolve_Target = tgt; Resolve_PredTarget = ptgt; Resolve_PC_Plus4 = pc4;
  endtask

  task automatic random_inputs();
    STALL       = ($urandom_range(0, 3) == 0);
    Pred_Valid  = $urandom_range(0, 1) == 1;
    Pred_Taken  = $urandom_range(0, 1) == 1;
    Pred_Target = $urandom;
    Resolve_Valid     = $urandom_range(0, 1) == 1;
    Resolve_Taken     = $urandom_range(0, 1) == 1;
    Resolve_PredTaken = $urandom_range(0, 1) == 1;
    Resolve_Target    = $urandom;
    Resolve_PredTarget = ($urandom_range(0, 1) == 1) ? Resolve_Target : $urandom;
    Resolve_PC_Plus4  = $urandom & 32'hFFFFFFFC;
  endtask

  initial begin
    clear_inputs();
    RESET = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RESET = 1;

    step("boot");
    step("seq1");
    step("seq2");

    Pred_Valid = 1; Pred_Taken = 1; Pred_Target = 32'h00400100;
    step("pred");
    STALL = 1;
    step("pred_stall");
    clear_inputs();

    set_resolve(0, 1, 32'h00400200, 32'h0, 32'h00400010);
    STALL = 1;
    step("mp_stall");
    clear_inputs();
    step("recover_exit");

    set_resolve(1, 0, 32'h00400500, 32'h00400500, 32'h00400010);
    step("mp_nottaken");
    clear_inputs();
    step("after_nt");

    set_resolve(1, 1, 32'h00400300, 32'h00400304, 32'h00400040);
    step("mp_target");
    clear_inputs();
    step("after_tgt");

    set_resolve(1, 1, 32'h00400700, 32'h00400700, 32'h00400080);
    step("good_pred");
    clear_inputs();

    Pred_Valid = 1; Pred_Taken = 1; Pred_Target = 32'hFFFFFFFF;
    step("to_top");
    clear_inputs();
    step("wrap");

    for (int i = 0; i < 600; i++) begin
      random_inputs();
      step("rand");
    end

    // Asynchronous reset in the middle of a redirect.
    set_resolve(0, 1, 32'h12345678, 32'h0, 32'h00001000);
    step("pre_reset_mp");
    clear_inputs();
    #2;
    RESET = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge CLK);
    RESET = 1;
    step("boot2");
    for (int i = 0; i < 200; i++) begin
      random_inputs();
      step("rand2");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Owns the fetch PC register and picks the next fetch address each cycle from three sources: sequential PC+4, the branch predictor's target, or a corrected target from the decode-stage resolution.
- Resolution comes from the next-instruction calculator.
- Detects mispredictions, issues a flush, inserts one recovery bubble, and sends training updates back to the predictor.
- Sits between the predictor, the IF stage and the ID-stage next-instruction logic.

Parameters:
RESET_VECTOR, 32'hBFC00000, first fetch address after reset.
CNT_W, 16, width of the saturating branch and mispredict counters.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-low reset.
STALL  input  1  IF stage cannot accept a new PC this cycle.
Pred_Valid  input  1  predictor output is valid for the current Fetch_PC.
Pred_Taken  input  1  predictor says taken.
Pred_Target  input  32  predicted target.
Resolve_Valid  input  1  ID stage resolved a branch or jump this cycle.
Resolve_Taken  input  1  actual direction (jumps always 1).
Resolve_Target  input  32  actual target from the next-instruction calculator.
Resolve_PC_Plus4  input  32  branch PC+4, which is the delay-slot address.
Resolve_PredTaken  input  1  prediction that was made for this branch.
Resolve_PredTarget  input  32  predicted target that was used for this branch.
Fetch_PC  output  32  address to fetch.
Fetch_Valid  output  1  Fetch_PC is a real fetch and not a bubble.
Flush  output  1  kill IF-stage instructions younger than the delay slot.
Update_Valid  output  1  predictor training strobe.
Update_PC  output  32  resolved branch PC (Resolve_PC_Plus4 - 4).
Update_Taken  output  1  actual direction.
Update_Target  output  32  actual target.
Branch_Count  output  CNT_W  number of resolved branches and jumps.
Mispredict_Count  output  CNT_W  number of mispredictions.

Behaviour:
- Reset (RESET=0, asynchronous):
  - Fetch_PC=RESET_VECTOR; Fetch_Valid=0; Flush=0.
  - Update_Valid=0; Update_PC/Update_Target=0; Update_Taken=0; both counters=0.
  - State=BOOT.
  - A reset asserted mid-redirect discards the pending redirect.
- FSM states: BOOT, RUN, RECOVER.
  - BOOT: Fetch_Valid=0. Unconditionally goes to RUN on the next edge with Fetch_PC unchanged.
  - RUN: Fetch_Valid=1.
  - RECOVER: Fetch_Valid=0 for exactly one cycle, then RUN. Fetch_PC holds the corrected address.
- Mispredict (combinational):
  - MP = Resolve_Valid & ((Resolve_Taken != Resolve_PredTaken) | (Resolve_Taken & Resolve_PredTaken & Resolve_Target != Resolve_PredTarget)).
  - Corrected PC = Resolve_Taken ? Resolve_Target : Resolve_PC_Plus4 + 4. The delay slot is always kept.
- Next-PC priority, evaluated each edge:
  1. MP in any non-BOOT state: Fetch_PC <= corrected; Flush <= 1; state <= RECOVER. STALL is ignored. In RECOVER the newest redirect wins and RECOVER restarts.
  2. STALL: Fetch_PC, Fetch_Valid and state hold.
  3. RUN with Pred_Valid & Pred_Taken: Fetch_PC <= Pred_Target.
  4. RUN otherwise: Fetch_PC <= Fetch_PC + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  5. RECOVER without MP: Fetch_PC holds; state <= RUN.
- MP during BOOT: ignored.
- Flush is a registered one-cycle pulse; it deasserts the following cycle unless MP recurs.
- Address alignment: the low 2 bits of every loaded target are forced to 0, so Fetch_PC[1:0] is always 0.
- Training: Resolve_Valid registers Update_* and pulses Update_Valid one cycle later, in any state except BOOT. STALL does not affect training.
- Counters:
  - Branch_Count increments on each Resolve_Valid.
  - Mispredict_Count increments on each MP.
  - Both saturate at all-ones and never wrap.
- Latency: resolution to corrected Fetch_PC is 1 cycle; resolution to first valid corrected fetch is 2 cycles.

Test Plan:
- Reset release -> cycle 0: BOOT, Fetch_PC=BFC00000, Fetch_Valid=0. Cycle 1: Fetch_Valid=1. Then Fetch_PC steps BFC00004, BFC00008 with no prediction.
- Pred_Valid=1, Pred_Taken=1, Pred_Target=00400100 in RUN -> next Fetch_PC=00400100. Same stimulus with STALL=1 -> Fetch_PC holds.
- Resolve_Valid, PredTaken=0, Taken=1, Target=00400200, STALL=1 -> next cycle Fetch_PC=00400200, Flush=1, Fetch_Valid=0. Cycle after: Flush=0, Fetch_Valid=1. Mispredict_Count=1.
- PredTaken=1, Taken=0, PC_Plus4=00400010 -> Fetch_PC=00400014. Taken with target mismatch 00400300 vs 00400304 -> MP=1, redirect to 00400300.
- Fetch_PC=FFFFFFFC, no prediction -> wraps to 00000000. Counters forced to FFFF then one more mispredict -> both stay FFFF. Assert RESET during RECOVER -> all outputs return to reset values immediately.
